vc_rr_scheduler: RTL and testbench
==================================

// Module: vc_rr_scheduler
// PURPOSE
//  Round-robin scheduler between the 4 input FIFOs (virtual channels) and the 4 output FIFOs.
//  - Picks one non-empty input FIFO, pops one word, latches it, and pushes it to the output FIFO
//    selected by the word's class field.
//  - Honours per-output almost_full backpressure and the FSM's active-state enable.
//  - Replaces the fixed-priority pop/push logic in the transaction layer.
// PARAMETERS
//  DATA_W     12  word width of the FIFO datapath
//  CLASS_LSB  10  class field = data[CLASS_LSB+1:CLASS_LSB], selects the output FIFO
//  STALL_W    8   width of the saturating stall counter
// PORTS
//  clk             in   1        single clock, all logic on rising edge
//  reset_L         in   1        synchronous, active-low reset
//  enable          in   1        1 = FSM in ACTIVE state, new pops allowed
//  empty_in        in   4        empty flags of input FIFOs 0..3
//  in_data0..3     in   DATA_W   data_out of input FIFOs 0..3 (valid cycle after pop)
//  almost_full_out in   4        almost_full flags of output FIFOs 0..3
//  pop_in          out  4        one-hot pop to input FIFOs
//  push_out        out  4        one-hot push to output FIFOs
//  data_out        out  DATA_W   data to output FIFOs, valid when push_out!=0
//  grant_idx       out  2        index of the channel currently in flight
//  busy            out  1        1 when state != IDLE
//  stall_cnt       out  STALL_W  cycles spent stalled in SEND, saturating
// BEHAVIOUR
//  Reset:
//   - When reset_L=0 at a clk edge: state=IDLE, rr_ptr=0, hold_data=0, hold_cls=0, stall_cnt=0.
//   - Outputs pop_in, push_out, data_out, grant_idx and busy are all 0.
//   - Any in-flight word is dropped.
//  States: IDLE, READ, SEND.
//  Arbitration (combinational, used in IDLE and in SEND when a push happens):
//   - Scan channels rr_ptr, rr_ptr+1, ... mod 4.
//   - Grant g = first channel with empty_in[g]=0.
//   - A pop is issued only when enable=1 and at least one channel is non-empty.
//  IDLE:
//   - If a grant exists: pop_in[g]=1, grant_idx<=g, rr_ptr<=g+1 (mod 4), next state READ.
//   - Otherwise outputs stay 0 and the state stays IDLE.
//  READ (1 cycle, FIFO read latency = 1):
//   - hold_data <= in_data[grant_idx].
//   - hold_cls <= in_data[grant_idx][CLASS_LSB+1:CLASS_LSB].
//   - Next state SEND. pop_in=0.
//  SEND, case almost_full_out[hold_cls]=0:
//   - push_out[hold_cls]=1 and data_out=hold_data, combinational from registers.
//   - If a grant also exists: pop the next channel in the same cycle and go to READ.
//   - Otherwise go to IDLE.
//  SEND, case almost_full_out[hold_cls]=1:
//   - push_out=0, pop_in=0, stay in SEND.
//   - stall_cnt+1, saturating at 2^STALL_W-1 (no wrap).
//  Throughput and latency:
//   - Sustained throughput is 1 word per 2 cycles.
//   - Latency is pop at cycle N to push at cycle N+2 when there is no stall.
//  Boundary conditions:
//   - empty_in is sampled only at pop time.
//   - Popping an empty FIFO never occurs.
//   - pop_in and push_out are each one-hot or zero; never more than 1 bit set.
//   - enable falling while in READ/SEND: the in-flight word completes normally.
//     No new pop is issued and the next state is IDLE.
//   - Backpressure on one class blocks all channels (head-of-line), by design.
//   - Reset mid-READ/SEND: the word is lost and no push occurs.
//     The input FIFO pop already happened.
//   - data_out=0 whenever push_out=0.
// TESTING
//  T1 reset:
//   - Drive reset_L=0 for 2 cycles with all inputs active.
//   - Expect pop_in=0, push_out=0, data_out=0, busy=0, stall_cnt=0.
//  T2 single word:
//   - enable=1, empty_in=4'b1101, in_data1=12'hA05 (class 2).
//   - Expect pop_in=4'b0010 at N, then push_out=4'b0100 and data_out=12'hA05 at N+2.
//  T3 round robin:
//   - All empty_in=0, enable=1, no backpressure.
//   - Expect pops on channels 0,1,2,3,0 at cycles N, N+2, N+4, N+6, N+8.
//  T4 backpressure:
//   - Word of class 3 with almost_full_out[3]=1 for 5 cycles in SEND.
//   - Expect no push and no pop for those cycles, and stall_cnt=5.
//   - Push occurs in the first cycle after the flag is released.
//  T5 enable drop:
//   - Deassert enable during READ.
//   - Expect the word still pushed at N+2, then IDLE, and no further pops while enable=0.
//  T6 reset mid-flight / saturation:
//   - Reset asserted in SEND: no push, IDLE next cycle.
//   - Hold a stall for 300 cycles: stall_cnt stops at 255.

Source files
------------

// File: rtl/vc_rr_scheduler.sv
// Round-robin mover from 4 input FIFOs to 4 class-selected output FIFOs; pop->push latency 2, one word per 2 cycles.
// A full output class (almost_full) stalls the word in SEND and blocks every channel until it drains.
module vc_rr_scheduler #(
  parameter int DATA_W    = 12,
  parameter int CLASS_LSB = 10,
  parameter int STALL_W   = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               enable,
  input  logic [3:0]         empty_in,
  input  logic [DATA_W-1:0]  in_data0,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [DATA_W-1:0]  in_data2,
  input  logic [DATA_W-1:0]  in_data3,
  input  logic [3:0]         almost_full_out,
  output logic [3:0]         pop_in,
  output logic [3:0]         push_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [1:0]         grant_idx,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr;
  logic [1:0]          grant_q;
  logic [DATA_W-1:0]   hold_data;
  logic [1:0]          hold_cls;
  logic [1:0]          grant;
  logic                grant_vld;
  logic                send_ok;
  logic                do_pop;
  logic [DATA_W-1:0]   sel_data;

  // First non-empty channel scanning upward from rr_ptr with 2-bit wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = rr_ptr + 2'(i);
      if (!grant_vld && !empty_in[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    sel_data = in_data0;
    case (grant_q)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  assign send_ok = (state == SEND) && !almost_full_out[hold_cls];
  // A new pop is only allowed once the previous word has left (IDLE or a push this cycle).
  assign do_pop  = reset_L && enable && grant_vld && ((state == IDLE) || send_ok);

  always_ff @(posedge clk) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = do_pop ? READ : IDLE;
      READ:    state_nxt = SEND;
      SEND:    if (send_ok) state_nxt = do_pop ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_in    = do_pop ? (4'b0001 << grant) : 4'b0000;
    push_out  = (reset_L && send_ok) ? (4'b0001 << hold_cls) : 4'b0000;
    data_out  = (reset_L && send_ok) ? hold_data : '0;
    busy      = reset_L && (state != IDLE);
    grant_idx = reset_L ? grant_q : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rr_ptr    <= 2'd0;
      grant_q   <= 2'd0;
      hold_data <= '0;
      hold_cls  <= 2'd0;
      stall_cnt <= '0;
    end else begin
      if (do_pop) begin
        grant_q <= grant;
        rr_ptr  <= grant + 2'd1;
      end
      if (state == READ) begin
        hold_data <= sel_data;
        hold_cls  <= sel_data[CLASS_LSB+1:CLASS_LSB];
      end
      if ((state == SEND) && almost_full_out[hold_cls] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// Bench for vc_rr_scheduler: queue-backed input FIFOs, a transaction-level model checked every cycle, directed pins plus random traffic.
module tb_vc_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enable;
  logic [3:0]  empty_in;
  logic [11:0] din [4];
  logic [3:0]  almost_full_out;
  logic [3:0]  pop_in;
  logic [3:0]  push_out;
  logic [11:0] data_out;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [7:0]  stall_cnt;

  always #5 clk = ~clk;

  vc_rr_scheduler #(.DATA_W(12), .CLASS_LSB(10), .STALL_W(8)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .empty_in(empty_in),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .almost_full_out(almost_full_out), .pop_in(pop_in), .push_out(push_out),
    .data_out(data_out), .grant_idx(grant_idx), .busy(busy), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] q [4][$];

  // Model: one word at a time; age 0 = popped this cycle's predecessor (being read), >0 = waiting to push.
  bit          m_inflight;
  int          m_age;
  logic [11:0] m_word;
  int          m_gidx;
  int          m_ptr;
  int          m_stall;

  logic [31:0] obs_pop, obs_push, obs_data, obs_busy, obs_gidx, obs_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0; m_age = 0; m_word = '0; m_gidx = 0; m_ptr = 0; m_stall = 0;
  endtask

  task automatic cycle();
    logic [31:0] e_pop, e_push, e_data, e_busy, e_gidx, e_stall;
    logic [1:0]  cls;
    logic [11:0] popped;
    bit          sending, push_ok, pop_ok, gv;
    int          g;
    for (int i = 0; i < 4; i++) empty_in[i] = (q[i].size() == 0);
    #1;
    cls     = m_word[11:10];
    sending = m_inflight && (m_age > 0);
    push_ok = sending && !almost_full_out[cls];
    gv = 1'b0; g = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_ptr + i) % 4;
      if (!gv && !empty_in[c]) begin gv = 1'b1; g = c; end
    end
    pop_ok  = reset_L && enable && gv && (!m_inflight || push_ok);
    e_pop   = pop_ok ? (1 << g) : 0;
    e_push  = (reset_L && push_ok) ? (1 << cls) : 0;
    e_data  = (e_push != 0) ? 32'(m_word) : 0;
    e_busy  = (reset_L && m_inflight) ? 1 : 0;
    e_gidx  = reset_L ? m_gidx : 0;
    e_stall = m_stall;

    obs_pop   = 32'(pop_in);
    obs_push  = 32'(push_out);
    obs_data  = 32'(data_out);
    obs_busy  = 32'(busy);
    obs_gidx  = 32'(grant_idx);
    obs_stall = 32'(stall_cnt);
    chk("pop_in", obs_pop, e_pop);
    chk("push_out", obs_push, e_push);
    chk("data_out", obs_data, e_data);
    chk("busy", obs_busy, e_busy);
    chk("grant_idx", obs_gidx, e_gidx);
    chk("stall_cnt", obs_stall, e_stall);

    popped = '0;
    if (!reset_L) begin
      model_reset();
    end else begin
      if (sending && almost_full_out[cls] && m_stall < 255) m_stall++;
      if (m_inflight && m_age == 0) m_age = 1;
      else if (push_ok) m_inflight = 1'b0;
      if (pop_ok) begin
        popped     = q[g].pop_front();
        m_inflight = 1'b1;
        m_age      = 0;
        m_word     = popped;
        m_gidx     = g;
        m_ptr      = (g + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    if (pop_ok) din[g] = popped;
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    reset_L = 1'b0;
    cycle();
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; enable = 1'b1; almost_full_out = 4'h0; empty_in = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 12'hFFF;
    model_reset();
    @(negedge clk);

    // T1: reset with all inputs active
    for (int i = 0; i < 4; i++) q[i].push_back(12'hC00 | 12'(i));
    cycle();
    cycle();
    chk("t1_pop", obs_pop, 'h0);
    chk("t1_push", obs_push, 'h0);
    chk("t1_data", obs_data, 'h0);
    chk("t1_busy", obs_busy, 'h0);
    do_reset();
    chk("t1_stall", obs_stall, 'h0);

    // T2: single word on channel 1, class 2
    q[1].push_back(12'hA05);
    cycle();
    chk("t2_pop", obs_pop, 'h2);
    cycle();
    chk("t2_read_busy", obs_busy, 'h1);
    cycle();
    chk("t2_push", obs_push, 'h4);
    chk("t2_data", obs_data, 'hA05);
    cycle();
    chk("t2_idle_busy", obs_busy, 'h0);

    // T3: round robin across all full channels
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) q[i].push_back(12'($urandom));
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (k % 2 == 0) chk("t3_pop", obs_pop, 32'(1 << ((k / 2) % 4)));
    end

    // T4: class-3 word held by backpressure for 5 cycles
    do_reset();
    q[0].push_back(12'hC37);
    q[1].push_back(12'h001);
    cycle();
    chk("t4_pop", obs_pop, 'h1);
    cycle();
    almost_full_out = 4'b1000;
    repeat (5) begin
      cycle();
      chk("t4_stall_push", obs_push, 'h0);
      chk("t4_stall_pop", obs_pop, 'h0);
    end
    almost_full_out = 4'h0;
    cycle();
    chk("t4_push", obs_push, 'h8);
    chk("t4_data", obs_data, 'hC37);
    chk("t4_stall_cnt", obs_stall, 'h5);
    chk("t4_next_pop", obs_pop, 'h2);
    cycle(); cycle();

    // T5: enable drops during READ
    do_reset();
    q[2].push_back(12'h123);
    q[3].push_back(12'h456);
    cycle();
    chk("t5_pop", obs_pop, 'h4);
    enable = 1'b0;
    cycle();
    cycle();
    chk("t5_push", obs_push, 'h1);
    chk("t5_data", obs_data, 'h123);
    chk("t5_no_pop", obs_pop, 'h0);
    repeat (3) begin
      cycle();
      chk("t5_idle_pop", obs_pop, 'h0);
      chk("t5_idle_busy", obs_busy, 'h0);
    end
    enable = 1'b1;

    // T6: reset in SEND, then stall counter saturation
    do_reset();
    q[0].push_back(12'h456);
    almost_full_out = 4'b0010;
    cycle(); cycle(); cycle();
    chk("t6_stalled", obs_push, 'h0);
    almost_full_out = 4'h0;
    reset_L = 1'b0;
    cycle();
    chk("t6_rst_push", obs_push, 'h0);
    chk("t6_rst_data", obs_data, 'h0);
    reset_L = 1'b1;
    cycle();
    chk("t6_idle_busy", obs_busy, 'h0);
    q[1].push_back(12'hC00);
    almost_full_out = 4'b1000;
    repeat (302) cycle();
    chk("t6_saturate", obs_stall, 'hFF);
    almost_full_out = 4'h0;
    cycle();
    chk("t6_push", obs_push, 'h8);
    chk("t6_data", obs_data, 'hC00);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      enable  = ($urandom_range(0, 9) != 0);
      reset_L = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 4; i++) begin
        almost_full_out[i] = ($urandom_range(0, 3) == 0);
        if (q[i].size() < 4 && $urandom_range(0, 2) == 0) q[i].push_back(12'($urandom));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
